// File: rtl/never8_pkg.sv
// Shared opcode map and sequencer state encoding for the Never8 ALU datapath.
// Imported by the controller and the ALU model.
package never8_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_SYS = 3'b111;

    localparam logic [4:0] HALT_IMM = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu8bit.sv
// Never8 combinational ALU: b op a, with a zero flag and a carry / no-borrow flag.
// Latency: none (purely combinational).
// Backpressure: none; outputs follow inputs.
module alu8bit
    import never8_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic [4:0] a,
    input  logic [7:0] b,
    output logic [7:0] data_out,
    output logic       zflag,
    output logic       c
);

    logic [8:0] sum;

    always_comb begin
        sum      = '0;
        data_out = '0;
        c        = 1'b0;
        case (opcode)
            OP_ADD: begin
                sum      = {1'b0, b} + {4'b0000, a};
                data_out = sum[7:0];
                c        = sum[8];
            end
            OP_SUB: begin
                // c is the inverted borrow, so 1 means b >= a
                sum      = {1'b0, b} - {4'b0000, a};
                data_out = sum[7:0];
                c        = ~sum[8];
            end
            OP_AND: data_out = b & {3'b000, a};
            OP_OR:  data_out = b | {3'b000, a};
            OP_XOR: data_out = b ^ {3'b000, a};
            OP_SHR: begin
                data_out = {1'b0, b[7:1]};
                c        = b[0];
            end
            default: data_out = '0;
        endcase
    end

    assign zflag = (data_out == 8'h00);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences Never8 instructions through the ALU and writes acc/zf/cf back.
// Latency: accept to done is EXEC_CYCLES+1 for ALU ops, 1 for LDI/NOP/HALT.
// Backpressure: instr_ready is low outside IDLE, while halted, and during reset.
module alu_seq_ctrl
    import never8_pkg::*;
#(
    parameter logic [7:0] ACC_RESET   = 8'h00,
    parameter int         EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic [2:0] alu_opcode,
    output logic [4:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic       alu_zflag,
    input  logic       alu_c,
    output logic [7:0] acc,
    output logic       zf,
    output logic       cf,
    output logic       done,
    output logic       halted
);

    localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] ir;
    logic [3:0] cnt;
    logic       accept;
    logic       is_alu_op;
    logic       exec_last;

    assign accept    = instr_valid && instr_ready;
    assign is_alu_op = (instr[7:5] != OP_LDI) && (instr[7:5] != OP_SYS);
    assign exec_last = (state == EXEC) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !halted && !rst;
                if (accept) begin
                    state_nxt = is_alu_op ? EXEC : WB;
                end
            end
            EXEC: begin
                if (exec_last) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Non-ALU instructions take effect on the accept edge so acc is settled while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir     <= 8'h00;
            cnt    <= 4'd0;
            acc    <= ACC_RESET;
            zf     <= 1'b0;
            cf     <= 1'b0;
            halted <= 1'b0;
        end else begin
            if (accept) begin
                ir  <= instr;
                cnt <= 4'd0;
                if (instr[7:5] == OP_LDI) begin
                    acc <= {3'b000, instr[4:0]};
                    zf  <= (instr[4:0] == 5'd0);
                end
                if (instr == {OP_SYS, HALT_IMM}) begin
                    halted <= 1'b1;
                end
            end
            if (state == EXEC) begin
                if (exec_last) begin
                    acc <= alu_result;
                    zf  <= alu_zflag;
                    cf  <= alu_c;
                    cnt <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    assign alu_opcode = ir[7:5];
    assign alu_a      = ir[4:0];
    assign alu_b      = acc;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and randomized checks of alu_seq_ctrl driving alu8bit, against an arithmetic model.
module tb_alu_seq_ctrl;
    import never8_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // EXEC_CYCLES = 1 instance
    logic       rst1, v1;
    logic [7:0] in1;
    logic       r1, d1, zf1, cf1, h1;
    logic [7:0] acc1, b1, res1;
    logic [2:0] op1;
    logic [4:0] a1;
    logic       az1, ac1;

    // EXEC_CYCLES = 4 instance
    logic       rst4, v4;
    logic [7:0] in4;
    logic       r4, d4, zf4, cf4, h4;
    logic [7:0] acc4, b4, res4;
    logic [2:0] op4;
    logic [4:0] a4;
    logic       az4, ac4;

    alu_seq_ctrl #(.ACC_RESET(8'h00), .EXEC_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1), .instr_valid(v1), .instr(in1), .instr_ready(r1),
        .alu_opcode(op1), .alu_a(a1), .alu_b(b1), .alu_result(res1),
        .alu_zflag(az1), .alu_c(ac1), .acc(acc1), .zf(zf1), .cf(cf1),
        .done(d1), .halted(h1)
    );
    alu8bit u_alu1 (.opcode(op1), .a(a1), .b(b1), .data_out(res1), .zflag(az1), .c(ac1));

    alu_seq_ctrl #(.ACC_RESET(8'h00), .EXEC_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst4), .instr_valid(v4), .instr(in4), .instr_ready(r4),
        .alu_opcode(op4), .alu_a(a4), .alu_b(b4), .alu_result(res4),
        .alu_zflag(az4), .alu_c(ac4), .acc(acc4), .zf(zf4), .cf(cf4),
        .done(d4), .halted(h4)
    );
    alu8bit u_alu4 (.opcode(op4), .a(a4), .b(b4), .data_out(res4), .zflag(az4), .c(ac4));

    int done_cnt4 = 0;
    int acpt_cnt4 = 0;
    always @(posedge clk) begin
        if (d4) done_cnt4++;
        if (v4 && r4) acpt_cnt4++;
    end

    // reference architectural state of the EXEC_CYCLES=1 instance
    int unsigned m_acc;
    logic        m_zf, m_cf, m_halt;

    function automatic void model_reset();
        m_acc  = 0;
        m_zf   = 1'b0;
        m_cf   = 1'b0;
        m_halt = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] ins);
        int unsigned op, imm, a;
        op  = int'(ins[7:5]);
        imm = int'(ins[4:0]);
        a   = m_acc;
        case (op)
            0: begin m_cf = (a + imm) > 255; m_acc = (a + imm) % 256; end
            1: begin m_cf = (a >= imm);      m_acc = (a + 256 - imm) % 256; end
            2: begin m_cf = 1'b0;            m_acc = a & imm; end
            3: begin m_cf = 1'b0;            m_acc = a | imm; end
            4: begin m_cf = 1'b0;            m_acc = a ^ imm; end
            5: begin m_cf = (a % 2) == 1;    m_acc = a / 2; end
            6: begin m_acc = imm; m_zf = (imm == 0); end
            default: if (imm == 31) m_halt = 1'b1;
        endcase
        if (op < 6) m_zf = (m_acc == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction to the EXEC_CYCLES=1 instance and check timing and results.
    task automatic run1(input logic [7:0] ins, input string tag);
        int n;
        int lat;
        int exp_lat;
        n = 0;
        while (!r1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, ".ready"}, 32'(r1), 1);
        v1  = 1'b1;
        in1 = ins;
        @(posedge clk); #1;
        v1  = 1'b0;
        in1 = 8'($urandom);
        model_step(ins);
        exp_lat = (ins[7:5] < 3'd6) ? 2 : 1;
        lat = 1;
        while (!d1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, ".lat"},    32'(lat),  32'(exp_lat));
        chk({tag, ".acc"},    32'(acc1), m_acc);
        chk({tag, ".zf"},     32'(zf1),  32'(m_zf));
        chk({tag, ".cf"},     32'(cf1),  32'(m_cf));
        chk({tag, ".halted"}, 32'(h1),   32'(m_halt));
        @(posedge clk); #1;
        chk({tag, ".done_1cyc"}, 32'(d1), 0);
        chk({tag, ".ready_after"}, 32'(r1), 32'(!m_halt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int low, dn, done_at, n, seen, a_before, d_before;
        logic [7:0] ins;

        rst1 = 1'b1; v1 = 1'b0; in1 = 8'h00;
        rst4 = 1'b1; v4 = 1'b0; in4 = 8'h00;
        model_reset();
        #1;
        chk("rst.acc",    32'(acc1), 0);
        chk("rst.done",   32'(d1),   0);
        chk("rst.halted", 32'(h1),   0);
        chk("rst.ready",  32'(r1),   0);
        @(posedge clk); @(posedge clk); #1;
        rst1 = 1'b0; rst4 = 1'b0;
        #1;
        chk("rst.ready_rel", 32'(r1), 1);
        chk("rst.zf",        32'(zf1), 0);
        chk("rst.cf",        32'(cf1), 0);
        chk("rst.ready4",    32'(r4), 1);

        run1(8'hC5, "ldi5_a");
        run1(8'h01, "add1");
        run1(8'hC5, "ldi5_b");
        run1(8'h25, "sub5");
        run1(8'hC5, "ldi5_c");
        run1(8'h26, "sub6");
        run1(8'h1F, "add_carry");

        for (int i = 0; i < 40; i++) begin
            ins = 8'($urandom);
            if (ins == 8'hFF) ins = 8'hE0;
            run1(ins, $sformatf("rnd%0d", i));
        end

        run1(8'hE0, "nop");
        run1(8'hFF, "halt");
        chk("halt.ready", 32'(r1), 0);

        // halted controller must ignore a held valid
        v1 = 1'b1; in1 = 8'h01; seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (d1 || r1) seen++;
        end
        v1 = 1'b0;
        chk("halt.ignored", 32'(seen), 0);
        chk("halt.acc",     32'(acc1), m_acc);
        chk("halt.sticky",  32'(h1),   1);
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        #1;
        model_reset();
        chk("unhalt.halted", 32'(h1),   0);
        chk("unhalt.ready",  32'(r1),   1);
        chk("unhalt.acc",    32'(acc1), 0);
        run1(8'hC3, "post_rst_ldi");

        // EXEC_CYCLES=4: preload 5, then ADD 1 with valid held through the op
        v4 = 1'b1; in4 = 8'hC5;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        chk("e4.ldi_acc", 32'(acc4), 8'h05);
        a_before = acpt_cnt4;
        d_before = done_cnt4;
        v4 = 1'b1; in4 = 8'h01;
        @(posedge clk); #1;
        low = 0; dn = 0; done_at = 0; n = 0;
        while (!r4 && n < 50) begin
            low++;
            if (d4) begin dn++; done_at = low; end
            @(posedge clk); #1; n++;
        end
        v4 = 1'b0;
        chk("e4.ready_low", 32'(low), 5);
        chk("e4.done_cnt",  32'(dn), 1);
        chk("e4.latency",   32'(done_at), 5);
        chk("e4.acc",       32'(acc4), 8'h06);
        @(posedge clk); #1;
        chk("e4.accepts",   32'(acpt_cnt4 - a_before), 1);
        chk("e4.dones",     32'(done_cnt4 - d_before), 1);

        // reset during the second EXEC cycle aborts the ADD
        v4 = 1'b1; in4 = 8'h01;
        @(posedge clk); #1;
        v4 = 1'b0;
        d_before = done_cnt4;
        @(posedge clk); #1;
        chk("e4abort.busy", 32'(r4), 0);
        rst4 = 1'b1;
        #1;
        chk("e4abort.acc",   32'(acc4), 0);
        chk("e4abort.done",  32'(d4), 0);
        chk("e4abort.ready", 32'(r4), 0);
        @(posedge clk); #1;
        rst4 = 1'b0;
        #1;
        chk("e4abort.ready_rel", 32'(r4), 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        chk("e4abort.no_done", 32'(done_cnt4 - d_before), 0);
        chk("e4abort.acc_kept", 32'(acc4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
